// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the rate scheduler.
// State encoding is visible on the state port, so the codes are fixed.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StTurn  = 2'd2,
    StPause = 2'd3
  } sched_state_e;

  localparam int unsigned DefaultDiv   = 50;
  localparam int unsigned DefaultWidth = 4;
  // Wide enough for the largest legal DIV (63).
  localparam int unsigned PrescWidth   = 6;

endpackage

// File: rtl/tick_prescaler.sv
// Slow-rate prescaler: counts 0..DIV-1 and flags the last count with slow_ok.
module tick_prescaler
  import counter_sched_pkg::*;
#(
  parameter int unsigned DIV = DefaultDiv
) (
  input  logic clk_1,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic slow_ok
);

  localparam logic [PrescWidth-1:0] Last = PrescWidth'(DIV - 1);

  logic [PrescWidth-1:0] cnt;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == Last) ? '0 : cnt + PrescWidth'(1);
    end
  end

  assign slow_ok = (cnt == Last);

endmodule

// File: rtl/counter_rate_sched.sv
// Rate scheduler driving a bouncing up/down counter datapath.
// Define COUNTER_RATE_SCHED_DEBOUNCE_EN to filter the button through DB_CYCLES samples.
module counter_rate_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned DIV       = DefaultDiv,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned WIDTH     = DefaultWidth
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             x,
  input  logic             button,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] count_val,
  output logic             tick,
  output logic             dir,
  output logic             mode,
  output logic [1:0]       state
);

  if (DIV < 2 || DIV > 63) begin : g_div_range
    $error("DIV must lie in 2..63");
  end
  if (DB_CYCLES < 1) begin : g_db_range
    $error("DB_CYCLES must be at least 1");
  end

  logic x_meta, x_sync, x_prev;
  logic btn_meta, btn_sync, btn_db;

  // x_prev trails x_sync so a rate change can restart the prescaler.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      x_meta   <= 1'b0;
      x_sync   <= 1'b0;
      x_prev   <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      x_meta   <= x;
      x_sync   <= x_meta;
      x_prev   <= x_sync;
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

`ifdef COUNTER_RATE_SCHED_DEBOUNCE_EN
  localparam int unsigned        DbW    = $clog2(DB_CYCLES + 1);
  localparam logic [DbW-1:0]     DbLast = DbW'(DB_CYCLES - 1);

  logic [DbW-1:0] db_cnt;

  // db_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DbLast) begin
      db_cnt <= '0;
      btn_db <= btn_sync;
    end else begin
      db_cnt <= db_cnt + DbW'(1);
    end
  end
`else
  assign btn_db = btn_sync;
`endif

  sched_state_e st;
  logic         at_bound;
  logic         slow_ok;
  logic         presc_clr;
  logic         presc_hold;

  assign at_bound   = mode ? (count_val == '0) : (count_val == '1);
  assign presc_clr  = (st == StIdle) || (x_sync != x_prev);
  assign presc_hold = (st == StPause);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk_1  (clk_1),
    .rst    (rst),
    .clr    (presc_clr),
    .hold   (presc_hold),
    .slow_ok(slow_ok)
  );

  // Suppressing the tick at the bound keeps the counter from overshooting.
  assign tick  = (st == StRun) && (x_sync || slow_ok) && !at_bound;
  assign state = st;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      st   <= StIdle;
      mode <= 1'b0;
      dir  <= 1'b0;
    end else begin
      dir <= btn_db ^ mode;
      if (stop && (st != StIdle)) begin
        st <= StIdle;
      end else begin
        unique case (st)
          StIdle: begin
            if (start) st <= StRun;
          end
          StRun: begin
            if (start) begin
              st <= StPause;
            end else if (at_bound) begin
              st <= StTurn;
            end
          end
          StTurn: begin
            // dir follows the new mode in the same edge to avoid a stale cycle.
            mode <= ~mode;
            dir  <= btn_db ^ ~mode;
            st   <= StRun;
          end
          StPause: begin
            if (start) st <= StRun;
          end
          default: st <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/counter_rate_sched.md
COUNTER_RATE_SCHED -- requirements
Module: counter_rate_sched

Interface
REQ-001 SHALL have parameter DIV, default 50, meaning slow-rate period in clk_1 cycles (2..63).
REQ-002 SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive stable samples needed to accept a button change.
REQ-003 SHALL have parameter WIDTH, default 4, meaning the datapath counter width.
REQ-004 SHALL have port clk_1, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port x, input, 1 bit: rate select; 1 = fast (every cycle), 0 = slow (every DIV cycles).
REQ-007 SHALL have port button, input, 1 bit: raw asynchronous direction request.
REQ-008 SHALL have port start, input, 1 bit: single-cycle run request.
REQ-009 SHALL have port stop, input, 1 bit: single-cycle halt request.
REQ-010 SHALL have port count_val, input, WIDTH bits: counter value fed back from the datapath.
REQ-011 SHALL have port tick, output, 1 bit: count-enable pulse to the datapath.
REQ-012 SHALL have port dir, output, 1 bit: count direction; 0 = up, 1 = down.
REQ-013 SHALL have port mode, output, 1 bit: bounce phase; 0 = ascending phase, 1 = descending phase.
REQ-014 SHALL have port state, output, 2 bits: current FSM state code.

Function
REQ-015 SHALL synchronise button and x each through two flops before any use.
REQ-016 SHALL update debounced btn_db only after DB_CYCLES consecutive equal synchronised samples.
REQ-017 SHALL run a prescaler counting 0..DIV-1 and wrapping to 0, with slow_ok high when it equals DIV-1.
REQ-018 SHALL clear the prescaler to 0 on any change of synchronised x and whenever state is IDLE.
REQ-019 SHALL implement FSM states IDLE=0, RUN=1, TURN=2, PAUSE=3.
REQ-020 SHALL transition IDLE->RUN on start.
REQ-021 SHALL transition RUN->TURN when count_val equals the active bound: all-ones if mode=0, zero if mode=1.
REQ-022 SHALL toggle mode in TURN and transition TURN->RUN after exactly one cycle.
REQ-023 SHALL transition RUN->PAUSE on start and PAUSE->RUN on start; PAUSE holds the prescaler value.
REQ-024 SHALL transition any non-IDLE state to IDLE on stop, with stop taking priority over start when both are asserted.
REQ-025 SHALL drive tick combinationally: state==RUN AND (x_sync OR slow_ok) AND count_val not equal to the active bound, so the counter never overshoots a bound.
REQ-026 SHALL drive dir = btn_db XOR mode, registered, so that with button released the counter bounces 0->max->0.
REQ-027 SHALL take a start arriving while count_val is already at the active bound directly to RUN, then to TURN on the next cycle, with no tick.

Reset
REQ-028 SHALL, on rst asserted, immediately force state=IDLE, mode=0, dir=0, tick=0, prescaler=0, btn_db=0 and all synchronisers to 0.
REQ-029 SHALL abort any operation in progress on reset; the first start after rst deasserts begins from mode=0.

Configuration
REQ-030 SHALL, with macro COUNTER_RATE_SCHED_DEBOUNCE_EN defined, include the DB_CYCLES debouncer.
REQ-031 SHALL, without COUNTER_RATE_SCHED_DEBOUNCE_EN, set btn_db equal to the synchronised button (two-cycle latency) and ignore DB_CYCLES.

Structure
REQ-032 SHALL place the state enum, state codes and default DIV/WIDTH constants in shared package counter_sched_pkg.
REQ-033 SHALL implement the prescaler as sub-module tick_prescaler (ports clk_1, rst, clr, hold, slow_ok).

Verification
REQ-034 SHALL verify fast bounce: x=1, button=0, start at count_val=0 -> 15 consecutive ticks with dir=0, then TURN for 1 cycle, then mode=1 and dir=1.
REQ-035 SHALL verify slow rate: x=0, DIV=50 -> tick exactly once every 50 cycles; toggling x mid-run restarts spacing from 0.
REQ-036 SHALL verify debounce: a 3-cycle button glitch with DB_CYCLES=4 -> dir unchanged; a 4-cycle stable press -> dir flips after sync latency plus 4 cycles.
REQ-037 SHALL verify simultaneous start and stop in RUN -> state=IDLE next cycle and tick=0.
REQ-038 SHALL verify rst asserted mid-RUN with mode=1 -> all outputs return to reset values asynchronously, before the next clk_1 edge.
REQ-039 SHALL verify PAUSE: start in RUN, wait 100 cycles, then start -> no ticks during PAUSE, and slow-mode tick spacing resumes from the held prescaler count.
